irq_gateway: RTL and testbench

Per-source interrupt gateway for the platform interrupt controller. It captures external interrupt requests into pending bits, which feed the priority max-finding stage. It also consumes the claim/complete traffic returned from the hart-facing side: claim clears a pending bit, and complete re-arms the source. Each source runs a small IDLE/PENDING/CLAIMED state machine, so a source cannot re-enter the pending set until its handler completes.

---
 rtl/irq_gateway.sv | 139 +++++++++++++
 tb/tb_irq_gateway.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: captures level/edge requests into pending bits and
// tracks claim/complete so a source cannot re-pend until its handler completes.
module irq_gateway #(
    parameter int SRC_N   = 31,
    parameter int ID_W    = $clog2(SRC_N + 1),
    parameter int SYNC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SRC_N-1:0] i_irq,
    input  logic [SRC_N-1:0] i_edge_mode,
    input  logic             i_claim_vld,
    input  logic [ID_W-1:0]  i_claim_id,
    input  logic             i_cmpl_vld,
    input  logic [ID_W-1:0]  i_cmpl_id,
    output logic [SRC_N-1:0] o_pending,
    output logic [SRC_N-1:0] o_claimed,
    output logic             o_irq_any
);

    // State encoding is {pending, claimed}; both set is unreachable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b10,
        ST_CLM  = 2'b01
    } src_state_e;

    logic [SRC_N-1:0] w_irq_s;
    logic [SRC_N-1:0] w_rise;
    logic [SRC_N-1:0] w_trig;
    logic [SRC_N-1:0] w_retrig;
    logic [SRC_N-1:0] w_claim_hit;
    logic [SRC_N-1:0] w_cmpl_hit;
    logic [SRC_N-1:0] w_pending_nxt;
    logic [SRC_N-1:0] w_claimed_nxt;
    logic [SRC_N-1:0] w_queued_nxt;

    logic [SRC_N-1:0] r_irq_prev;
    logic [SRC_N-1:0] r_pending;
    logic [SRC_N-1:0] r_claimed;
    logic [SRC_N-1:0] r_queued;
    logic             r_irq_any;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [SRC_N-1:0] r_sync1;
            logic [SRC_N-1:0] r_sync2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                end else begin
                    r_sync1 <= i_irq;
                    r_sync2 <= r_sync1;
                end
            end

            assign w_irq_s = r_sync2;
        end else begin : g_nosync
            assign w_irq_s = i_irq;
        end
    endgenerate

    assign w_rise   = w_irq_s & ~r_irq_prev;
    assign w_trig   = (i_edge_mode & w_rise) | (~i_edge_mode & w_irq_s);
    assign w_retrig = (i_edge_mode & (r_queued | w_rise)) | (~i_edge_mode & w_irq_s);

    // IDs 0 and >SRC_N never decode to a source, so they fall out as no-ops.
    always_comb begin
        w_claim_hit = '0;
        w_cmpl_hit  = '0;
        for (int k = 0; k < SRC_N; k++) begin
            w_claim_hit[k] = i_claim_vld && (i_claim_id == ID_W'(k + 1));
            w_cmpl_hit[k]  = i_cmpl_vld && (i_cmpl_id == ID_W'(k + 1));
        end
    end

    always_comb begin
        w_pending_nxt = r_pending;
        w_claimed_nxt = r_claimed;
        w_queued_nxt  = r_queued;
        for (int k = 0; k < SRC_N; k++) begin
            case (src_state_e'({r_pending[k], r_claimed[k]}))
                ST_IDLE: begin
                    if (w_trig[k]) begin
                        w_pending_nxt[k] = 1'b1;
                    end
                end
                ST_PEND: begin
                    if (w_claim_hit[k]) begin
                        w_pending_nxt[k] = 1'b0;
                        w_claimed_nxt[k] = 1'b1;
                    end
                    if (w_rise[k]) begin
                        w_queued_nxt[k] = 1'b1;
                    end
                end
                ST_CLM: begin
                    if (w_cmpl_hit[k]) begin
                        w_claimed_nxt[k] = 1'b0;
                        if (w_retrig[k]) begin
                            w_pending_nxt[k] = 1'b1;
                            w_queued_nxt[k]  = 1'b0;
                        end
                    end else if (w_rise[k]) begin
                        w_queued_nxt[k] = 1'b1;
                    end
                end
                default: ;
            endcase
            // A level source has nothing to remember between handler runs.
            if (!i_edge_mode[k]) begin
                w_queued_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_claimed  <= '0;
            r_queued   <= '0;
            r_irq_any  <= 1'b0;
        end else begin
            r_irq_prev <= w_irq_s;
            r_pending  <= w_pending_nxt;
            r_claimed  <= w_claimed_nxt;
            r_queued   <= w_queued_nxt;
            r_irq_any  <= |r_pending;
        end
    end

    assign o_pending = r_pending;
    assign o_claimed = r_claimed;
    assign o_irq_any = r_irq_any;

endmodule

// File: tb/tb_irq_gateway.sv
// Bench for irq_gateway (4 sources, synchronizer on): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural source model.
module tb_irq_gateway;

    localparam int N      = 4;
    localparam int IW     = 3;
    localparam int S_IDLE = 0;
    localparam int S_PEND = 1;
    localparam int S_CLM  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic [N-1:0]  emode;
    logic          cv;
    logic [IW-1:0] cid;
    logic          pv;
    logic [IW-1:0] pid;
    logic [N-1:0]  o_pending;
    logic [N-1:0]  o_claimed;
    logic          o_irq_any;

    int total = 0;
    int bad   = 0;

    // Behavioural model: integer state per source, one queued-event flag,
    // and a two-deep history of sampled lines standing in for the synchronizer.
    int           st[N]   = '{default: S_IDLE};
    bit           qd[N]   = '{default: 1'b0};
    logic [N-1:0] hist[2] = '{default: '0};
    logic [N-1:0] m_prev  = '0;
    logic         m_any   = 1'b0;

    irq_gateway #(.SRC_N(N), .ID_W(IW), .SYNC_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_irq       (irq),
        .i_edge_mode (emode),
        .i_claim_vld (cv),
        .i_claim_id  (cid),
        .i_cmpl_vld  (pv),
        .i_cmpl_id   (pid),
        .o_pending   (o_pending),
        .o_claimed   (o_claimed),
        .o_irq_any   (o_irq_any)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] vec_of(input int s);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k] = (st[k] == s);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            st[k] = S_IDLE;
            qd[k] = 1'b0;
        end
        hist[0] = '0;
        hist[1] = '0;
        m_prev  = '0;
        m_any   = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        logic [N-1:0] rise;
        bit           claim;
        bit           cmpl;
        bit           em;
        s       = hist[1];
        hist[1] = hist[0];
        hist[0] = irq;
        rise    = s & ~m_prev;
        m_prev  = s;
        m_any   = (vec_of(S_PEND) != '0);
        for (int k = 0; k < N; k++) begin
            claim = cv && (int'(cid) == k + 1);
            cmpl  = pv && (int'(pid) == k + 1);
            em    = emode[k];
            if (st[k] == S_IDLE) begin
                if (em ? rise[k] : s[k]) st[k] = S_PEND;
            end else if (st[k] == S_PEND) begin
                if (claim) st[k] = S_CLM;
                if (em && rise[k]) qd[k] = 1'b1;
            end else begin
                if (cmpl) begin
                    if (em ? (qd[k] || rise[k]) : s[k]) begin
                        st[k] = S_PEND;
                        qd[k] = 1'b0;
                    end else begin
                        st[k] = S_IDLE;
                    end
                end else if (em && rise[k]) begin
                    qd[k] = 1'b1;
                end
            end
            if (!em) qd[k] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_pending", o_pending, vec_of(S_PEND));
            chk("model_claimed", o_claimed, vec_of(S_CLM));
            chk("model_irq_any", {3'b000, o_irq_any}, {3'b000, m_any});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic claim(input int id);
        cv  = 1'b1;
        cid = IW'(id);
        tick();
        cv  = 1'b0;
        cid = '0;
    endtask

    task automatic complete(input int id);
        pv  = 1'b1;
        pid = IW'(id);
        tick();
        pv  = 1'b0;
        pid = '0;
    endtask

    task automatic pulse(input int k);
        irq[k] = 1'b1;
        tick();
        irq[k] = 1'b0;
        tick();
    endtask

    task automatic both(input logic [N-1:0] ep, input logic [N-1:0] ec, input string name);
        chk({name, "_pend"}, o_pending, ep);
        chk({name, "_clm"}, o_claimed, ec);
    endtask

    initial begin
        rst = 1'b1; irq = '0; emode = '0;
        cv = 1'b0; cid = '0; pv = 1'b0; pid = '0;
        repeat (3) tick();
        both(4'b0000, 4'b0000, "reset");
        chk("reset_any", {3'b000, o_irq_any}, 4'b0000);
        rst = 1'b0;
        tick();

        // Level source 3: latency through synchronizer, claim, complete after drop
        irq = 4'b0100;
        tick(); chk("lat_e0", o_pending, 4'b0000);
        tick(); chk("lat_e1", o_pending, 4'b0000);
        tick(); chk("lat_e2", o_pending, 4'b0100);
        chk("any_lag", {3'b000, o_irq_any}, 4'b0000);
        tick(); chk("any_set", {3'b000, o_irq_any}, 4'b0001);
        claim(3);  both(4'b0000, 4'b0100, "claim3");
        irq = 4'b0000;
        repeat (3) tick();
        complete(3); both(4'b0000, 4'b0000, "cmpl3_idle");
        tick(); chk("any_clear", {3'b000, o_irq_any}, 4'b0000);

        // Level line held high: complete re-pends on the same edge
        irq = 4'b0001;
        repeat (3) tick(); chk("lvl1_pend", o_pending, 4'b0001);
        claim(1);    both(4'b0000, 4'b0001, "claim1");
        complete(1); both(4'b0001, 4'b0000, "cmpl1_repend");
        irq = 4'b0000;
        repeat (3) tick();
        claim(1); complete(1); both(4'b0000, 4'b0000, "lvl1_idle");

        // Edge source 2: three pulses while claimed collapse to one queued event
        emode = 4'b0010;
        tick();
        pulse(1);
        repeat (3) tick(); both(4'b0010, 4'b0000, "edge2_pend");
        claim(2); both(4'b0000, 4'b0010, "edge2_claim");
        repeat (3) begin pulse(1); tick(); end
        repeat (3) tick(); both(4'b0000, 4'b0010, "edge2_hold");
        complete(2); both(4'b0010, 4'b0000, "edge2_queued");
        claim(2);    both(4'b0000, 4'b0010, "edge2_claim2");
        complete(2); both(4'b0000, 4'b0000, "edge2_idle");

        // Illegal traffic against pending source 1 (line dropped while pending)
        irq = 4'b0001;
        repeat (3) tick(); chk("ill_setup", o_pending, 4'b0001);
        irq = 4'b0000;
        repeat (3) tick(); both(4'b0001, 4'b0000, "lvl_drop_keeps");
        claim(0);    both(4'b0001, 4'b0000, "ill_claim0");
        claim(5);    both(4'b0001, 4'b0000, "ill_claim5");
        claim(7);    both(4'b0001, 4'b0000, "ill_claim7");
        claim(4);    both(4'b0001, 4'b0000, "ill_claim_idle4");
        complete(1); both(4'b0001, 4'b0000, "ill_cmpl_pend1");

        // Simultaneous claim 1 / complete 2
        pulse(1);
        repeat (3) tick(); both(4'b0011, 4'b0000, "sim_setup");
        claim(2); both(4'b0001, 4'b0010, "sim_claim2");
        cv = 1'b1; cid = 3'd1; pv = 1'b1; pid = 3'd2;
        tick();
        cv = 1'b0; cid = '0; pv = 1'b0; pid = '0;
        both(4'b0000, 4'b0001, "sim_both");

        // Asynchronous reset mid-operation, then level re-trigger
        irq = 4'b0100;
        repeat (3) tick(); chk("rst_setup3", o_pending, 4'b0100);
        claim(3); both(4'b0000, 4'b0101, "rst_claim3");
        irq = 4'b0000;
        pulse(1);
        repeat (3) tick(); both(4'b0010, 4'b0101, "rst_setup2");
        irq = 4'b0001; emode = 4'b0000;
        tick();
        rst = 1'b1;
        #1;
        both(4'b0000, 4'b0000, "rst_async");
        chk("rst_async_any", {3'b000, o_irq_any}, 4'b0000);
        tick(); tick();
        rst = 1'b0;
        tick(); chk("post_rst_e0", o_pending, 4'b0000);
        tick(); chk("post_rst_e1", o_pending, 4'b0000);
        tick(); both(4'b0001, 4'b0000, "post_rst_e2");
        tick(); chk("post_rst_any", {3'b000, o_irq_any}, 4'b0001);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
